// File: rtl/wots_chain_lengths_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : wots_chain_lengths_pkg
//  Brief    : Shared WOTS parameters, mode encodings and FSM state encodings
//             used by the WOTS chain blocks.
//  Revision : 1.0 - initial release
// ============================================================================
package wots_chain_lengths_pkg;

    // Winternitz parameter and digit width (only w = 16 is supported)
    localparam int WOTS_W_DFLT     = 16;
    localparam int WOTS_LOG_W_DFLT = 4;

    // Chain counts: message digits, checksum digits, total chains
    localparam int LEN1 = 64;
    localparam int LEN2 = 3;
    localparam int LEN  = LEN1 + LEN2;

    // Checksum register width; the largest checksum is 64 * 15 = 960
    localparam int CSUM_W = 12;

    // Operation modes
    typedef logic [1:0] mode_t;
    localparam mode_t MODE_PKGEN  = 2'd0;
    localparam mode_t MODE_SIGN   = 2'd1;
    localparam mode_t MODE_VERIFY = 2'd2;
    localparam mode_t MODE_RSVD   = 2'd3;

    // Controller states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MSG  = 2'd1;
    localparam state_t ST_CSUM = 2'd2;
    localparam state_t ST_FIN  = 2'd3;

endpackage : wots_chain_lengths_pkg
`default_nettype wire

// File: rtl/wots_chain_lengths.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : wots_chain_lengths
//  Brief    : Walks the 67 WOTS chains of one digest and emits one registered
//             chain descriptor (start/end step, skip, raw digit) per chain,
//             computing the base-w checksum on the fly.
//  Revision : 1.0 - initial release
// ============================================================================
module wots_chain_lengths
    import wots_chain_lengths_pkg::*;
#(
    parameter int WOTS_W     = WOTS_W_DFLT,
    parameter int WOTS_LOG_W = $clog2(WOTS_W),
    parameter int KEY_LEN    = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [KEY_LEN-1:0]    msg,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [6:0]            chain_idx,
    output logic [WOTS_LOG_W-1:0] start_step,
    output logic [WOTS_LOG_W-1:0] end_step,
    output logic                  skip,
    output logic [WOTS_LOG_W-1:0] digit,
    output logic                  done
);

    localparam logic [WOTS_LOG_W-1:0] STEP_LAST = WOTS_LOG_W'(WOTS_W - 2);
    localparam logic [WOTS_LOG_W-1:0] DIGIT_MAX = WOTS_LOG_W'(WOTS_W - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [KEY_LEN-1:0]      r_msg;
    mode_t                   r_mode;
    logic [CSUM_W-1:0]       r_csum;

    logic [KEY_LEN-1:0]      w_src_msg;
    mode_t                   w_src_mode;
    logic [CSUM_W-1:0]       w_csum_upd;
    logic                    w_accept;
    logic                    w_hs;
    logic                    w_last_hs;
    logic                    w_load;
    logic [6:0]              w_next_idx;
    logic [WOTS_LOG_W-1:0]   w_next_digit;
    logic [WOTS_LOG_W-1:0]   w_next_start;
    logic [WOTS_LOG_W-1:0]   w_next_end;
    logic                    w_next_skip;

    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_hs      = out_valid && out_ready;
    assign w_last_hs = w_hs && (chain_idx == 7'(LEN - 1));
    assign w_load    = w_accept || (w_hs && !w_last_hs);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: starts are only honoured in IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_MSG;
            ST_MSG:  if (w_hs && (chain_idx == 7'(LEN1 - 1))) w_state_next = ST_CSUM;
            ST_CSUM: if (w_last_hs) w_state_next = ST_FIN;
            ST_FIN:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs: busy covers descriptor emission, done is the FIN pulse
    always_comb begin
        busy = (r_state == ST_MSG) || (r_state == ST_CSUM);
        done = (r_state == ST_FIN);
    end

    // Checksum including the digit being handed off this cycle (15 - d == ~d)
    always_comb begin
        w_csum_upd = r_csum;
        if ((r_state == ST_MSG) && w_hs) begin
            w_csum_upd = r_csum + {{(CSUM_W - WOTS_LOG_W){1'b0}}, ~digit};
        end
    end

    // Select the digit for the next descriptor; on acceptance read the inputs directly
    always_comb begin
        w_src_msg    = (r_state == ST_IDLE) ? msg  : r_msg;
        w_src_mode   = (r_state == ST_IDLE) ? mode : r_mode;
        w_next_idx   = (r_state == ST_IDLE) ? 7'd0 : chain_idx + 7'd1;
        w_next_digit = '0;
        for (int i = 0; i < LEN1; i++) begin
            if (w_next_idx == 7'(i)) begin
                w_next_digit = w_src_msg[KEY_LEN-1-WOTS_LOG_W*i -: WOTS_LOG_W];
            end
        end
        if (w_next_idx == 7'(LEN1)) begin
            w_next_digit = w_csum_upd[CSUM_W-1 -: WOTS_LOG_W];
        end
        if (w_next_idx == 7'(LEN1 + 1)) begin
            w_next_digit = w_csum_upd[CSUM_W-1-WOTS_LOG_W -: WOTS_LOG_W];
        end
        if (w_next_idx == 7'(LEN1 + 2)) begin
            w_next_digit = w_csum_upd[WOTS_LOG_W-1:0];
        end
    end

    // Map the digit to chain step range by mode; reserved mode behaves as PKGEN
    always_comb begin
        w_next_start = '0;
        w_next_end   = STEP_LAST;
        w_next_skip  = 1'b0;
        case (w_src_mode)
            MODE_SIGN: begin
                w_next_end  = w_next_digit - WOTS_LOG_W'(1);
                w_next_skip = (w_next_digit == '0);
            end
            MODE_VERIFY: begin
                w_next_start = w_next_digit;
                w_next_skip  = (w_next_digit == DIGIT_MAX);
            end
            default: begin
                w_next_start = '0;
            end
        endcase
    end

    // Datapath and descriptor registers; descriptor holds until handshaken
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_msg      <= '0;
            r_mode     <= MODE_PKGEN;
            r_csum     <= '0;
            out_valid  <= 1'b0;
            chain_idx  <= '0;
            start_step <= '0;
            end_step   <= '0;
            skip       <= 1'b0;
            digit      <= '0;
        end else begin
            if (w_accept) begin
                r_msg  <= msg;
                r_mode <= mode;
                r_csum <= '0;
            end else begin
                r_csum <= w_csum_upd;
            end
            if (w_load) begin
                out_valid  <= 1'b1;
                chain_idx  <= w_next_idx;
                start_step <= w_next_start;
                end_step   <= w_next_end;
                skip       <= w_next_skip;
                digit      <= w_next_digit;
            end else if (w_last_hs) begin
                out_valid  <= 1'b0;
            end
        end
    end

endmodule : wots_chain_lengths
`default_nettype wire

// File: tb/tb_wots_chain_lengths.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_wots_chain_lengths
//  Brief    : Directed self-checking bench for wots_chain_lengths.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wots_chain_lengths;
    import wots_chain_lengths_pkg::*;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   mode;
    logic [255:0] msg;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [6:0]   chain_idx;
    logic [3:0]   start_step;
    logic [3:0]   end_step;
    logic         skip;
    logic [3:0]   digit;
    logic         done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Per-run capture of accepted descriptors
    logic [6:0] cap_idx [0:69];
    logic [3:0] cap_st  [0:69];
    logic [3:0] cap_en  [0:69];
    logic       cap_sk  [0:69];
    logic [3:0] cap_dg  [0:69];
    int         n_cap;
    int         done_cyc;
    int         stable_cnt;
    logic       busy_at_done;

    localparam logic [255:0] PAT_0123 = {4{64'h0123456789ABCDEF}};

    wots_chain_lengths #(
        .WOTS_W     (16),
        .WOTS_LOG_W (4),
        .KEY_LEN    (256)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .msg        (msg),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .chain_idx  (chain_idx),
        .start_step (start_step),
        .end_step   (end_step),
        .skip       (skip),
        .digit      (digit),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] s, input logic [3:0] e, input logic k);
        return {23'd0, s, e, k};
    endfunction

    function automatic logic [31:0] cap3(input int i);
        return {23'd0, cap_st[i], cap_en[i], cap_sk[i]};
    endfunction

    function automatic logic [19:0] cur_desc();
        return {chain_idx, start_step, end_step, skip, digit};
    endfunction

    function automatic logic [31:0] all_outs();
        return {12'd0, busy, out_valid, done, skip, chain_idx, start_step, end_step, digit};
    endfunction

    // Start one run and accept descriptors, optionally stalling on one index
    task automatic run_capture(input logic [1:0] m, input logic [255:0] mg,
                               input int stall_idx, input int stall_len);
        int         stall_cnt;
        logic [19:0] ref_desc;
        n_cap        = 0;
        done_cyc     = -1;
        stable_cnt   = 0;
        stall_cnt    = 0;
        busy_at_done = 1'bx;
        ref_desc     = '0;
        @(negedge clk);
        start     = 1'b1;
        mode      = m;
        msg       = mg;
        out_ready = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                done_cyc     = cyc;
                busy_at_done = busy;
                break;
            end
            if (out_valid && (int'(chain_idx) == stall_idx) && (stall_cnt < stall_len)) begin
                if (stall_cnt == 0) ref_desc = cur_desc();
                else if (cur_desc() === ref_desc) stable_cnt++;
                if (stall_cnt == 2) begin
                    start = 1'b1;
                    mode  = MODE_VERIFY;
                    msg   = ~mg;
                end
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = 1'b1;
                if (out_valid && (n_cap < 70)) begin
                    cap_idx[n_cap] = chain_idx;
                    cap_st[n_cap]  = start_step;
                    cap_en[n_cap]  = end_step;
                    cap_sk[n_cap]  = skip;
                    cap_dg[n_cap]  = digit;
                    n_cap++;
                end
            end
        end
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int cnt;
        int done_seen;
        logic reached;

        reset     = 1'b0;
        start     = 1'b0;
        mode      = MODE_PKGEN;
        msg       = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", all_outs(), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_after_reset", all_outs(), 32'd0);

        // SIGN, msg = 0: every message chain skipped, csum 960 = 0x3C0
        run_capture(MODE_SIGN, '0, -1, 0);
        check("sign0_count", n_cap, 67);
        cnt = 0;
        for (int i = 0; i < 64; i++) if (cap_sk[i] === 1'b1) cnt++;
        check("sign0_msg_skips", cnt, 64);
        check("sign0_csum_digits", {20'd0, cap_dg[64], cap_dg[65], cap_dg[66]}, 32'h3C0);
        check("sign0_idx64", cap3(64), mk(4'd0, 4'd2, 1'b0));
        check("sign0_idx65", cap3(65), mk(4'd0, 4'd11, 1'b0));
        check("sign0_idx66_skip", cap_sk[66], 32'd1);
        check("sign0_done_cycle", done_cyc, 68);
        check("sign0_busy_at_done", busy_at_done, 32'd0);

        // SIGN, msg = all-ones: full (0,14) chains, csum 0 -> all skipped
        run_capture(MODE_SIGN, '1, -1, 0);
        cnt = 0;
        for (int i = 0; i < 64; i++) if (cap3(i) === mk(4'd0, 4'd14, 1'b0)) cnt++;
        check("sign1_msg_chains", cnt, 64);
        cnt = 0;
        for (int i = 64; i < 67; i++) if (cap_sk[i] === 1'b1) cnt++;
        check("sign1_csum_skips", cnt, 3);

        // VERIFY, 0123..EF pattern: csum 480 = 0x1E0
        run_capture(MODE_VERIFY, PAT_0123, -1, 0);
        check("ver_idx1", cap3(1), mk(4'd1, 4'd14, 1'b0));
        check("ver_idx15_skip", cap_sk[15], 32'd1);
        check("ver_csum_digits", {20'd0, cap_dg[64], cap_dg[65], cap_dg[66]}, 32'h1E0);
        check("ver_idx64", cap3(64), mk(4'd1, 4'd14, 1'b0));
        check("ver_idx65", cap3(65), mk(4'd14, 4'd14, 1'b0));
        check("ver_idx66", cap3(66), mk(4'd0, 4'd14, 1'b0));

        // PKGEN and reserved mode: uniform full chains, sequential indices
        run_capture(MODE_PKGEN, {8{32'hDEADBEEF}}, -1, 0);
        cnt = 0;
        for (int i = 0; i < n_cap; i++)
            if ((cap3(i) === mk(4'd0, 4'd14, 1'b0)) && (int'(cap_idx[i]) == i)) cnt++;
        check("pkgen_all", cnt, 67);
        run_capture(MODE_RSVD, {8{32'h13579BDF}}, -1, 0);
        cnt = 0;
        for (int i = 0; i < n_cap; i++)
            if ((cap3(i) === mk(4'd0, 4'd14, 1'b0)) && (int'(cap_idx[i]) == i)) cnt++;
        check("rsvd_all", cnt, 67);

        // Backpressure: 5 stalled cycles on index 10, a start pulse in the window
        run_capture(MODE_SIGN, PAT_0123, 10, 5);
        check("bp_stable", stable_cnt, 4);
        check("bp_idx10", {cap_idx[10], cap_dg[10]}, {7'd10, 4'hA});
        check("bp_idx10_desc", cap3(10), mk(4'd0, 4'd9, 1'b0));
        check("bp_idx11_desc", cap3(11), mk(4'd0, 4'd10, 1'b0));
        check("bp_csum_digits", {20'd0, cap_dg[64], cap_dg[65], cap_dg[66]}, 32'h1E0);
        check("bp_done_cycle", done_cyc, 73);

        // Mid-run reset at index 30
        @(negedge clk);
        start = 1'b1;
        mode  = MODE_SIGN;
        msg   = '1;
        out_ready = 1'b1;
        reached = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid && (chain_idx == 7'd30)) begin
                reached = 1'b1;
                break;
            end
        end
        check("rst_reached_30", {busy, reached}, 2'b11);
        reset = 1'b0;
        #1;
        check("rst_outputs_zero", all_outs(), 32'd0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        reset = 1'b1;
        repeat (80) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("rst_no_done", done_seen, 0);
        run_capture(MODE_SIGN, '0, -1, 0);
        check("rst_restart_idx0", {25'd0, cap_idx[0]}, 32'd0);
        check("rst_restart_csum", {20'd0, cap_dg[64], cap_dg[65], cap_dg[66]}, 32'h3C0);
        check("rst_restart_done", done_cyc, 68);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_wots_chain_lengths
`default_nettype wire

// File: doc/wots_chain_lengths.md
WOTS_CHAIN_LENGTHS -- requirements
Module: wots_chain_lengths

Interface
REQ-001 SHALL have parameter WOTS_W, default 16, Winternitz parameter; only 16 is supported.
REQ-002 SHALL have parameter WOTS_LOG_W, default `CLOG2(WOTS_W), bits per digit.
REQ-003 SHALL have parameter KEY_LEN, default 256, message digest width in bits.
REQ-004 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1: one-cycle request pulse.
REQ-007 SHALL have port mode, input, 2: 0=PKGEN, 1=SIGN, 2=VERIFY, 3=reserved (treated as PKGEN).
REQ-008 SHALL have port msg, input, KEY_LEN: digest; byte 0 is at [255:248].
REQ-009 SHALL have port busy, output, 1: high from the cycle after an accepted start until done.
REQ-010 SHALL have port out_valid, output, 1: the chain descriptor is valid.
REQ-011 SHALL have port out_ready, input, 1: the downstream chain controller accepts the descriptor.
REQ-012 SHALL have port chain_idx, output, 7: chain index, 0..66.
REQ-013 SHALL have port start_step, output, WOTS_LOG_W: value for the gen_chain start_step.
REQ-014 SHALL have port end_step, output, WOTS_LOG_W: value for the gen_chain end_step, inclusive.
REQ-015 SHALL have port skip, output, 1: the chain needs zero hashes; the consumer does not start gen_chain.
REQ-016 SHALL have port digit, output, WOTS_LOG_W: the raw base-w digit.
REQ-017 SHALL have port done, output, 1: one-cycle pulse after the last descriptor is accepted.

Function
REQ-018 SHALL accept start only in IDLE; on acceptance it SHALL latch msg and mode, clear csum and index, and enter MSG. Start while busy SHALL be ignored.
REQ-019 SHALL use FSM states IDLE, MSG, CSUM and FIN.
- MSG: emits indices 0..63.
- CSUM: emits 64..66.
- FIN: pulses done for one cycle, then returns to IDLE.
REQ-020 SHALL take message digit i (i=0..63) from msg, MSB-first: digit 0 = msg[255:252], digit 1 = msg[251:248], and so on.
REQ-021 SHALL add (15 - digit) to a 12-bit csum register on each MSG handshake (out_valid & out_ready). The maximum is 960, so no overflow occurs.
REQ-022 SHALL emit checksum digits 64, 65, 66 as csum[11:8], csum[7:4] and csum[3:0], in that order. This is equivalent to XMSS csum<<4 taken as 2 bytes in base w.
REQ-023 SHALL form the chain descriptor by mode:
- PKGEN: start 0, end 14, skip 0.
- SIGN: start 0, end d-1, skip=(d==0).
- VERIFY: start d, end 14, skip=(d==15).
REQ-024 SHALL present out_valid as a registered signal; the first descriptor appears 1 cycle after start is accepted.
REQ-025 SHALL hold all descriptor outputs stable while out_valid=1 and out_ready=0.
REQ-026 SHALL present the next descriptor in the cycle after each handshake, giving a sustained rate of 1 per cycle when out_ready=1.
REQ-027 SHALL make the index-64 descriptor use the csum that includes the digit-63 contribution; the register updates in the same edge as the handshake.
REQ-028 SHALL deassert out_valid in the cycle after the index-66 handshake, pulse done for 1 cycle, and drop busy in that same cycle.
REQ-029 SHALL ignore out_ready while out_valid=0.

Reset
REQ-030 SHALL, on reset low, asynchronously force:
- state=IDLE;
- busy, out_valid, done, skip = 0;
- chain_idx, start_step, end_step, digit, csum = 0.
REQ-031 SHALL abandon any run in progress on reset mid-run, with no done pulse; after reset release the next start SHALL begin a fresh run at index 0.

Structure
REQ-032 SHALL take WOTS_W, WOTS_LOG_W, LEN1=64, LEN2=3, LEN=67 and the mode encodings from the shared WOTS parameter header included by all WOTS blocks.
REQ-033 SHALL be a single module with no sub-module. The digit mux and step mapping are local combinational logic feeding the output registers.

Verification
REQ-034 SHALL cover SIGN with msg=0 and out_ready=1:
- indices 0..63 have skip=1;
- csum=960 gives digits 3, 12, 0;
- index 64 gives (0,2,0), index 65 gives (0,11,0), index 66 gives skip=1;
- done arrives 68 cycles after start.
REQ-035 SHALL cover SIGN with msg=all-ones:
- indices 0..63 give (0,14,0);
- csum=0, so indices 64..66 have skip=1.
REQ-036 SHALL cover VERIFY with msg=0x0123456789ABCDEF repeated:
- index 1 gives (1,14,0);
- index 15 has skip=1;
- csum=480=0x1E0 gives digits 1, 14, 0;
- index 64 gives (1,14,0), index 65 gives (14,14,0), index 66 gives (0,14,0).
REQ-037 SHALL cover PKGEN with arbitrary msg: all 67 descriptors are (0,14,0) with chain_idx increasing by 1.
REQ-038 SHALL cover backpressure: hold out_ready=0 for 5 cycles while index 10 is presented. Outputs stay stable, csum advances only once, and a start pulse in that window is ignored.
REQ-039 SHALL cover a mid-run reset: assert reset at index 30. All outputs read 0 immediately, no done pulse occurs, and a new start restarts at index 0 with the correct csum.
